// File: rtl/req_gnt_initiator.sv
// rtl/req_gnt_initiator.sv - requester side of the single-pulse req/gnt handshake
module req_gnt_initiator #(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             proto_err,
  output logic             start_drop,
  output logic [CNT_W-1:0] pending,
  output logic [CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int BW = (BACKOFF < 2) ? 1 : $clog2(BACKOFF);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BO_LAST   = BW'(BACKOFF - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_BACK, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RW-1:0]    r_retry;
  logic [RW-1:0]    w_retry_nxt;
  logic [BW-1:0]    r_bo;
  logic [BW-1:0]    w_bo_nxt;
  logic             w_grant;
  logic             w_abort;
  logic             w_retire;
  logic             w_drop;
  logic [CNT_W-1:0] w_pending_nxt;

  // A token retires in WAIT either by grant or by exhausting its retries.
  always_comb begin
    w_grant  = (r_state == S_WAIT) && gnt;
    w_abort  = (r_state == S_WAIT) && !gnt && (r_retry == RETRY_MAX);
    w_retire = w_grant || w_abort;
  end

  // Pending counter update: start and retire in the same cycle cancel out.
  always_comb begin
    w_pending_nxt = pending;
    w_drop        = 1'b0;
    if (start && !w_retire) begin
      if (&pending) begin
        w_drop = 1'b1;
      end else begin
        w_pending_nxt = pending + 1'b1;
      end
    end else if (!start && w_retire) begin
      w_pending_nxt = pending - 1'b1;
    end
  end

  // Next-state logic with retry and backoff bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_bo_nxt    = r_bo;
    case (r_state)
      S_IDLE: begin
        if (pending != '0) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (gnt) begin
          w_state_nxt = S_GAP;
        end else if (r_retry != RETRY_MAX) begin
          w_retry_nxt = r_retry + 1'b1;
          w_bo_nxt    = '0;
          w_state_nxt = S_BACK;
        end else begin
          w_retry_nxt = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_BACK: begin
        if (r_bo == BO_LAST) begin
          w_state_nxt = S_REQ;
        end else begin
          w_bo_nxt = r_bo + 1'b1;
        end
      end
      S_GAP: begin
        w_retry_nxt = '0;
        w_state_nxt = (w_pending_nxt != '0) ? S_REQ : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; req is registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_retry    <= '0;
      r_bo       <= '0;
      req        <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      proto_err  <= 1'b0;
      start_drop <= 1'b0;
      pending    <= '0;
      grant_cnt  <= '0;
      abort_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_retry    <= w_retry_nxt;
      r_bo       <= w_bo_nxt;
      req        <= (w_state_nxt == S_REQ);
      done       <= w_grant;
      abort      <= w_abort;
      proto_err  <= proto_err | (gnt && (r_state != S_WAIT));
      start_drop <= start_drop | w_drop;
      pending    <= w_pending_nxt;
      if (w_grant) grant_cnt <= grant_cnt + 1'b1;
      if (w_abort) abort_cnt <= abort_cnt + 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);

  // req is followed by at least two low cycles.
  a_req_gap1: assert property (@(posedge clk) disable iff (!reset_n) req |=> !req);
  a_req_gap2: assert property (@(posedge clk) disable iff (!reset_n) $past(req) |=> !req);
  // A retire is either a grant or an abort, never both.
  a_done_abort: assert property (@(posedge clk) disable iff (!reset_n) done |-> !abort);
  // A dropped start only happens from a saturated pending counter.
  a_drop_full: assert property (@(posedge clk) disable iff (!reset_n)
                                $rose(start_drop) |-> &$past(pending));

endmodule

// File: tb/tb_req_gnt_initiator.sv
// tb/tb_req_gnt_initiator.sv - self-checking bench for req_gnt_initiator
module tb_req_gnt_initiator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       gnt = 1'b0;
  logic       req, busy, done, abort, proto_err, start_drop;
  logic [7:0] pending, grant_cnt, abort_cnt;

  logic       start_b = 1'b0;
  logic       gnt_b = 1'b0;
  logic       req_b, busy_b, done_b, abort_b, proto_err_b, start_drop_b;
  logic [1:0] pending_b, grant_cnt_b, abort_cnt_b;

  req_gnt_initiator #(.CNT_W(8), .MAX_RETRY(3), .BACKOFF(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .gnt(gnt), .req(req), .busy(busy),
    .done(done), .abort(abort), .proto_err(proto_err), .start_drop(start_drop),
    .pending(pending), .grant_cnt(grant_cnt), .abort_cnt(abort_cnt)
  );

  req_gnt_initiator #(.CNT_W(2), .MAX_RETRY(3), .BACKOFF(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .gnt(gnt_b), .req(req_b), .busy(busy_b),
    .done(done_b), .abort(abort_b), .proto_err(proto_err_b), .start_drop(start_drop_b),
    .pending(pending_b), .grant_cnt(grant_cnt_b), .abort_cnt(abort_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_start;
    int gmode;      // 0: gnt = req delayed 1, 1: gnt tied 0, 2: gnt held 2 cycles
    int kind;       // 1: each token ends in done, 2: in abort
    int exp_grant;
    int exp_abort;
    int exp_reqs;
    int exp_space;  // 0: spacing not checked
    int exp_perr;
  } vec_t;

  vec_t vt[6];
  int   n_vec = 0;
  int   n_err = 0;
  int   q[$];
  int   cyc = 0;
  int   gmode = 1;
  logic req_neg = 1'b0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;
  int   req_count = 0;
  int   last_req_cyc = 0;
  bit   first_req = 1'b1;
  int   exp_space = 0;
  int   n_evt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle counter for req spacing measurements.
  always @(posedge clk) cyc++;

  // Responder model: drives gnt just after the edge from req seen in earlier cycles.
  initial forever begin
    @(posedge clk);
    #1;
    h2 = h1;
    h1 = req_neg;
    case (gmode)
      0:       gnt = h1;
      2:       gnt = h1 | h2;
      default: gnt = 1'b0;
    endcase
  end

  // Monitor: counts req pulses, checks spacing, pops scoreboard on done/abort.
  initial forever begin
    @(negedge clk);
    req_neg = req;
    if (reset_n) begin
      if (req) begin
        req_count++;
        if (!first_req && exp_space != 0) chk("req_spacing", cyc - last_req_cyc, exp_space);
        first_req = 1'b0;
        last_req_cyc = cyc;
      end
      if (done || abort) begin
        n_evt++;
        chk("done_abort_excl", {31'd0, done & abort}, 0);
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got done=%0b abort=%0b expected none", done, abort);
        end else begin
          chk("event_kind", done ? 1 : 2, q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    start_b = 1'b0;
    gnt_b = 1'b0;
    gmode = 1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    do_reset();
    gmode = v.gmode;
    req_count = 0;
    first_req = 1'b1;
    exp_space = v.exp_space;
    for (int i = 0; i < v.n_start; i++) begin
      @(posedge clk);
      #1 start = 1'b1;
      q.push_back(v.kind);
    end
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || pending != 0 || q.size() != 0) && k < 400);
    if (k >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL vec_timeout: got busy=%0b pending=%0d expected idle", busy, pending);
    end
    chk("grant_cnt", grant_cnt, v.exp_grant);
    chk("abort_cnt", abort_cnt, v.exp_abort);
    chk("pending_end", pending, 0);
    chk("busy_end", busy, 0);
    chk("proto_err", proto_err, v.exp_perr);
    chk("req_count", req_count, v.exp_reqs);
    chk("start_drop", start_drop, 0);
  endtask

  initial begin
    int k;
    vt[0] = '{1, 0, 1, 1, 0, 1, 0, 0};
    vt[1] = '{5, 0, 1, 5, 0, 5, 3, 0};
    vt[2] = '{1, 1, 2, 0, 1, 4, 4, 0};
    vt[3] = '{1, 2, 1, 1, 0, 1, 0, 1};
    vt[4] = '{3, 0, 1, 3, 0, 3, 3, 0};
    vt[5] = '{2, 1, 2, 0, 2, 8, 0, 0};

    do_reset();
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_abort", {done, abort}, 0);
    chk("rst_flags", {proto_err, start_drop}, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cnts", {grant_cnt, abort_cnt}, 0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Reset asserted while a request waits for grant.
    do_reset();
    exp_space = 0;
    n_evt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req && k < 20);
    chk("req_seen", req, 1);
    @(posedge clk);
    #2;
    chk("pending_in_wait", pending, 1);
    reset_n = 1'b0;
    #1;
    chk("async_req", req, 0);
    chk("async_pending", pending, 0);
    chk("async_busy", busy, 0);
    chk("async_cnts", {grant_cnt, abort_cnt}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_evt_after_rst", n_evt, 0);
    chk("idle_after_rst", {busy, pending}, 0);

    // Saturation on a 2-bit counter while the FSM sits in a long backoff.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 start_b = 1'b1;
    end
    @(posedge clk);
    #1 start_b = 1'b0;
    @(negedge clk);
    chk("sat_pending", pending_b, 3);
    chk("sat_drop", start_drop_b, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_b && k < 60);
    chk("sat_req_seen", req_b, 1);
    @(posedge clk);
    #1;
    gnt_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    gnt_b = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    chk("sat_hold_pending", pending_b, 3);
    chk("sat_done", done_b, 1);
    chk("sat_grant_cnt", grant_cnt_b, 1);
    chk("sat_proto_err", proto_err_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
